// File: rtl/tt_response_checker_if.sv
// Handshake bundle between a stimulus source (master) and tt_response_checker (slave).
// With TT_CHECKER_FIRST_FAIL_EN defined, the first-failure capture signals are also carried.
interface tt_response_checker_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned CNT_W = 8
);
  logic                   start;
  logic                   in_valid;
  logic [N_IN-1:0]        in_vec;
  logic                   dut_o;
  logic                   mismatch;
  logic [CNT_W-1:0]       err_cnt;
  logic [(1<<N_IN)-1:0]   cov_map;
  logic                   busy;
  logic                   done;
  logic                   pass;
`ifdef TT_CHECKER_FIRST_FAIL_EN
  logic [N_IN-1:0]        first_fail_vec;
  logic                   first_fail_o;
  logic                   first_fail_vld;

  modport master (
    output start, in_valid, in_vec, dut_o,
    input  mismatch, err_cnt, cov_map, busy, done, pass,
    input  first_fail_vec, first_fail_o, first_fail_vld
  );
  modport slave (
    input  start, in_valid, in_vec, dut_o,
    output mismatch, err_cnt, cov_map, busy, done, pass,
    output first_fail_vec, first_fail_o, first_fail_vld
  );
`else
  modport master (
    output start, in_valid, in_vec, dut_o,
    input  mismatch, err_cnt, cov_map, busy, done, pass
  );
  modport slave (
    input  start, in_valid, in_vec, dut_o,
    output mismatch, err_cnt, cov_map, busy, done, pass
  );
`endif
endinterface

// File: rtl/tt_response_checker.sv
// Sequential truth-table response checker with saturating error count and input coverage.
// Optional first-failure capture enabled by defining TT_CHECKER_FIRST_FAIL_EN.
module tt_response_checker #(
  parameter int unsigned          N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 8'b1110_1000,
  parameter int unsigned          CNT_W  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  tt_response_checker_if.slave bus
);
  localparam int unsigned TT_W = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;

  logic             exp_o;
  logic             miss;
  logic [CNT_W-1:0] cnt_next;
  logic [TT_W-1:0]  cov_next;

  always_comb begin
    exp_o    = EXP_TT[bus.in_vec];
    miss     = (bus.dut_o != exp_o);
    cnt_next = bus.err_cnt;
    if (miss && (bus.err_cnt != '1)) cnt_next = bus.err_cnt + CNT_W'(1);
    cov_next = bus.cov_map | (TT_W'(1) << bus.in_vec);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.mismatch <= 1'b0;
      bus.err_cnt  <= '0;
      bus.cov_map  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.pass     <= 1'b0;
`ifdef TT_CHECKER_FIRST_FAIL_EN
      bus.first_fail_vec <= '0;
      bus.first_fail_o   <= 1'b0;
      bus.first_fail_vld <= 1'b0;
`endif
    end else begin
      bus.mismatch <= 1'b0;
      // start has priority in every state and discards any sample in the same cycle
      if (bus.start) begin
        state       <= RUN;
        bus.err_cnt <= '0;
        bus.cov_map <= '0;
        bus.busy    <= 1'b1;
        bus.done    <= 1'b0;
        bus.pass    <= 1'b0;
`ifdef TT_CHECKER_FIRST_FAIL_EN
        bus.first_fail_vec <= '0;
        bus.first_fail_o   <= 1'b0;
        bus.first_fail_vld <= 1'b0;
`endif
      end else begin
        case (state)
          RUN: begin
            if (bus.in_valid) begin
              bus.mismatch <= miss;
              bus.err_cnt  <= cnt_next;
              bus.cov_map  <= cov_next;
`ifdef TT_CHECKER_FIRST_FAIL_EN
              if (miss && !bus.first_fail_vld) begin
                bus.first_fail_vec <= bus.in_vec;
                bus.first_fail_o   <= bus.dut_o;
                bus.first_fail_vld <= 1'b1;
              end
`endif
              if (cov_next == '1) begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.pass <= (cnt_next == '0);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: default instance plus a CNT_W=2 instance for saturation.
module tb_tt_response_checker;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tt_response_checker_if #(.N_IN(3), .CNT_W(8)) ifa ();
  tt_response_checker_if #(.N_IN(3), .CNT_W(2)) ifb ();

  tt_response_checker #(.N_IN(3), .EXP_TT(8'b1110_1000), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  tt_response_checker #(.N_IN(3), .EXP_TT(8'b1110_1000), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cycle(input logic st, input logic vld, input logic [2:0] v, input logic o);
    ifa.start = st; ifa.in_valid = vld; ifa.in_vec = v; ifa.dut_o = o;
    tick();
    ifa.start = 1'b0; ifa.in_valid = 1'b0;
  endtask

  task automatic b_cycle(input logic st, input logic vld, input logic [2:0] v, input logic o);
    ifb.start = st; ifb.in_valid = vld; ifb.in_vec = v; ifb.dut_o = o;
    tick();
    ifb.start = 1'b0; ifb.in_valid = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic mm, input logic [7:0] err, input logic [7:0] cov,
                       input logic bsy, input logic dn, input logic ps);
    check({tag, ".mismatch"}, 32'(ifa.mismatch), 32'(mm));
    check({tag, ".err_cnt"},  32'(ifa.err_cnt),  32'(err));
    check({tag, ".cov_map"},  32'(ifa.cov_map),  32'(cov));
    check({tag, ".busy"},     32'(ifa.busy),     32'(bsy));
    check({tag, ".done"},     32'(ifa.done),     32'(dn));
    check({tag, ".pass"},     32'(ifa.pass),     32'(ps));
  endtask

  initial begin
    logic [2:0] v;
    logic       o;
    logic       wrong;
    int         e;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_vec = '0; ifa.dut_o = 1'b0;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_vec = '0; ifb.dut_o = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_a("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.b_err", 32'(ifb.err_cnt), 32'd0);
`ifdef TT_CHECKER_FIRST_FAIL_EN
    check("reset.ff_vld", 32'(ifa.first_fail_vld), 32'd0);
`endif

    // Clean majority sweep
    a_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    chk_a("start1", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a_cycle(1'b0, 1'b1, v, maj(v));
      check($sformatf("clean.mm%0d", i), 32'(ifa.mismatch), 32'd0);
      if (i < 7) check($sformatf("clean.done%0d", i), 32'(ifa.done), 32'd0);
    end
    chk_a("clean.end", 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
    tick();
    chk_a("clean.hold", 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);

    // Sweep with vec 3 and vec 6 forced to 0
    a_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    chk_a("restart", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    e = 0;
    for (int i = 0; i < 8; i++) begin
      v     = 3'(i);
      wrong = (i == 3) || (i == 6);
      o     = wrong ? 1'b0 : maj(v);
      if (wrong) e++;
      a_cycle(1'b0, 1'b1, v, o);
      check($sformatf("bad.mm%0d", i), 32'(ifa.mismatch), 32'(wrong));
      check($sformatf("bad.err%0d", i), 32'(ifa.err_cnt), 32'(e));
    end
    chk_a("bad.end", 1'b0, 8'd2, 8'hFF, 1'b0, 1'b1, 1'b0);
`ifdef TT_CHECKER_FIRST_FAIL_EN
    check("bad.ff_vec", 32'(ifa.first_fail_vec), 32'd3);
    check("bad.ff_o",   32'(ifa.first_fail_o),   32'd0);
    check("bad.ff_vld", 32'(ifa.first_fail_vld), 32'd1);
`endif
    // in_valid in DONE is ignored
    a_cycle(1'b0, 1'b1, 3'd0, 1'b1);
    chk_a("done.ign", 1'b0, 8'd2, 8'hFF, 1'b0, 1'b1, 1'b0);
`ifdef TT_CHECKER_FIRST_FAIL_EN
    check("done.ff_vec", 32'(ifa.first_fail_vec), 32'd3);
`endif

    // Partial coverage, duplicates, then completion
    a_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd1, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd2, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd2, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd2, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd5, 1'b1);
    chk_a("part", 1'b0, 8'h00, 8'b0010_0111, 1'b1, 1'b0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd3, 1'b1);
    a_cycle(1'b0, 1'b1, 3'd4, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd6, 1'b1);
    check("part.done6", 32'(ifa.done), 32'd0);
    a_cycle(1'b0, 1'b1, 3'd7, 1'b1);
    chk_a("part.end", 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);

    // Saturation on the CNT_W=2 instance
    b_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      b_cycle(1'b0, 1'b1, 3'd0, 1'b1);
      check($sformatf("sat.mm%0d", i), 32'(ifb.mismatch), 32'd1);
      check($sformatf("sat.err%0d", i), 32'(ifb.err_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      b_cycle(1'b0, 1'b1, v, maj(v));
    end
    check("sat.err", 32'(ifb.err_cnt), 32'd3);
    check("sat.done", 32'(ifb.done), 32'd1);
    check("sat.pass", 32'(ifb.pass), 32'd0);

    // Reset mid-run
    a_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd1, 1'b1);
    a_cycle(1'b0, 1'b1, 3'd2, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd3, 1'b1);
    chk_a("mid", 1'b0, 8'd1, 8'h0F, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    a_cycle(1'b0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    chk_a("rst2", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef TT_CHECKER_FIRST_FAIL_EN
    check("rst2.ff_vld", 32'(ifa.first_fail_vld), 32'd0);
    check("rst2.ff_vec", 32'(ifa.first_fail_vec), 32'd0);
`endif
    a_cycle(1'b0, 1'b1, 3'd5, 1'b0);
    chk_a("idle.ign", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // start with a wrong sample in IDLE: sample discarded
    a_cycle(1'b1, 1'b1, 3'd7, 1'b0);
    chk_a("idle.st", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a_cycle(1'b0, 1'b1, v, maj(v));
    end
    chk_a("rst2.end", 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);

    // start in RUN together with a wrong sample
    a_cycle(1'b1, 1'b0, 3'd0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd0, 1'b0);
    check("run.cov", 32'(ifa.cov_map), 32'h01);
    a_cycle(1'b1, 1'b1, 3'd7, 1'b0);
    chk_a("run.st", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    a_cycle(1'b0, 1'b1, 3'd7, 1'b0);
    chk_a("run.after", 1'b1, 8'd1, 8'h80, 1'b1, 1'b0, 1'b0);
    a_cycle(1'b0, 1'b0, 3'd7, 1'b0);
    check("run.mm_idle", 32'(ifa.mismatch), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
